// File: rtl/keypad_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_pkg
//  Description : Shared constants, FSM state encoding and helper functions
//                for the 4x4 matrix keypad scanner.
//  Revision    : 1.0 - initial release
// ============================================================================
package keypad_scan_pkg;

    localparam int NROWS = 4;
    localparam int NCOLS = 4;
    localparam int KEY_W = 4;
    localparam int NKEYS = NROWS * NCOLS;
    localparam int ROW_W = 2;

    typedef enum logic [0:0] {
        ST_SCAN = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Index of the least-significant set bit; 0 when the vector is empty.
    function automatic logic [KEY_W-1:0] lowest_set(input logic [NKEYS-1:0] v);
        logic [KEY_W-1:0] idx;
        idx = '0;
        for (int i = NKEYS - 1; i >= 0; i--) begin
            if (v[i]) idx = KEY_W'(i);
        end
        return idx;
    endfunction

    // Active-low one-hot drive pattern for a row index.
    function automatic logic [NROWS-1:0] row_drive(input logic [ROW_W-1:0] row);
        return ~(NROWS'(1) << row);
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_sync.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_sync
//  Description : Two-flop synchronizer for the asynchronous column lines.
//                Reset presets both stages to 1s (the released level).
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                d    - asynchronous active-low column inputs
//                q    - synchronized column inputs
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_sync
    import keypad_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NCOLS-1:0] d,
    output logic [NCOLS-1:0] q
);

    logic [NCOLS-1:0] r_meta;
    logic [NCOLS-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/keypad_scan.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan
//  Description : 4x4 matrix keypad scanner with frame-level debounce and a
//                valid/ready event stream (one event per changed key).
//  Ports       : clk       - clock, all logic on rising edge
//                rst       - synchronous active-high reset
//                row_n     - active-low row drive, at most one bit low
//                col_n     - active-low column sense (asynchronous)
//                key_code  - event key index, row*4+col
//                key_press - 1 = press, 0 = release
//                key_valid - event available
//                key_ready - consumer accepts the event
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int clk_freq       = 95000,   // kHz
    parameter int row_per_us     = 100,     // dwell per row, microseconds
    parameter int debounce_scans = 8        // 1..255
) (
    input  logic             clk,
    input  logic             rst,
    output logic [NROWS-1:0] row_n,
    input  logic [NCOLS-1:0] col_n,
    output logic [KEY_W-1:0] key_code,
    output logic             key_press,
    output logic             key_valid,
    input  logic             key_ready
);

    localparam int                DWELL      = clk_freq * row_per_us / 1000;
    localparam int                DWELL_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(NROWS - 1);
    localparam logic [7:0]        DEB        = 8'(debounce_scans);

    state_t             r_state,     w_state_nxt;
    logic [ROW_W-1:0]   r_row,       w_row_nxt;
    logic [DWELL_W-1:0] r_dwell,     w_dwell_nxt;
    logic               r_run,       w_run_nxt;
    logic [NKEYS-1:0]   r_frame,     w_frame_nxt;
    logic [NKEYS-1:0]   r_prev,      w_prev_nxt;
    logic [NKEYS-1:0]   r_committed, w_committed_nxt;
    logic [7:0]         r_stable,    w_stable_nxt;
    logic               r_valid,     w_valid_nxt;
    logic [KEY_W-1:0]   r_code,      w_code_nxt;
    logic               r_press,     w_press_nxt;

    logic [NCOLS-1:0]   w_col_sync;
    logic [KEY_W-1:0]   w_row_slot;
    logic [NKEYS-1:0]   w_frame_full;
    logic [7:0]         w_stable_upd;
    logic               w_xfer;
    logic [NKEYS-1:0]   w_commit_upd;
    logic [NKEYS-1:0]   w_pending;
    logic [KEY_W-1:0]   w_first_idx;
    logic [KEY_W-1:0]   w_next_idx;

    keypad_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_n),
        .q   (w_col_sync)
    );

    // Frame as it would look with the current row's sample merged in.
    always_comb begin
        w_row_slot   = {r_row, 2'b00};
        w_frame_full = r_frame;
        w_frame_full[w_row_slot +: NCOLS] = ~w_col_sync;
    end

    always_comb begin
        w_stable_upd = 8'd0;
        if (w_frame_full == r_prev) begin
            w_stable_upd = (r_stable >= DEB) ? DEB : r_stable + 8'd1;
        end
    end

    // Committed map after this cycle's transfer; what remains is still owed.
    always_comb begin
        w_xfer       = r_valid & key_ready;
        w_commit_upd = r_committed;
        if (w_xfer) w_commit_upd[r_code] = r_press;
        w_pending    = w_commit_upd ^ r_prev;
    end

    assign w_first_idx = lowest_set(w_frame_full ^ r_committed);
    assign w_next_idx  = lowest_set(w_pending);

    always_comb begin
        w_state_nxt     = r_state;
        w_row_nxt       = r_row;
        w_dwell_nxt     = r_dwell;
        w_run_nxt       = r_run;
        w_frame_nxt     = r_frame;
        w_prev_nxt      = r_prev;
        w_committed_nxt = r_committed;
        w_stable_nxt    = r_stable;
        w_valid_nxt     = r_valid;
        w_code_nxt      = r_code;
        w_press_nxt     = r_press;

        case (r_state)
            ST_SCAN: begin
                if (!r_run) begin
                    // Hold counters for one cycle so row 0 gets a full
                    // dwell once row_n leaves its reset level.
                    w_run_nxt = 1'b1;
                end else if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_row_nxt   = r_row + ROW_W'(1);
                    w_frame_nxt = w_frame_full;
                    if (r_row == ROW_LAST) begin
                        w_prev_nxt   = w_frame_full;
                        w_stable_nxt = w_stable_upd;
                        if (w_stable_upd == DEB && w_frame_full != r_committed) begin
                            w_state_nxt = ST_EMIT;
                            w_valid_nxt = 1'b1;
                            w_code_nxt  = w_first_idx;
                            w_press_nxt = w_frame_full[w_first_idx];
                        end
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DWELL_W'(1);
                end
            end
            ST_EMIT: begin
                w_committed_nxt = w_commit_upd;
                if (|w_pending) begin
                    w_valid_nxt = 1'b1;
                    w_code_nxt  = w_next_idx;
                    w_press_nxt = r_prev[w_next_idx];
                end else begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_SCAN;
                    w_row_nxt   = '0;
                    w_dwell_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_SCAN;
            r_row       <= '0;
            r_dwell     <= '0;
            r_run       <= 1'b0;
            r_frame     <= '0;
            r_prev      <= '0;
            r_committed <= '0;
            r_stable    <= 8'd0;
            r_valid     <= 1'b0;
            r_code      <= '0;
            r_press     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_row       <= w_row_nxt;
            r_dwell     <= w_dwell_nxt;
            r_run       <= w_run_nxt;
            r_frame     <= w_frame_nxt;
            r_prev      <= w_prev_nxt;
            r_committed <= w_committed_nxt;
            r_stable    <= w_stable_nxt;
            r_valid     <= w_valid_nxt;
            r_code      <= w_code_nxt;
            r_press     <= w_press_nxt;
        end
    end

    assign row_n     = (r_state == ST_SCAN && r_run) ? row_drive(r_row) : '1;
    assign key_valid = r_valid;
    assign key_code  = r_code;
    assign key_press = r_press;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan
//  Description : Self-checking bench for keypad_scan with a frame-level
//                keypad model and an event scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan;

    localparam int DEB = 3;

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_press;
    logic        key_valid;
    logic        key_ready;

    logic [15:0] keys;
    logic [3:0]  glitch_n;
    int          rdy_mode = 1;
    int          chk_cnt  = 0;
    int          pass_cnt = 0;

    ev_t         exp_q[$];
    ev_t         mon_e;
    logic        st_hold = 1'b0;
    ev_t         st_ev;

    logic [15:0] m_prev;
    logic [15:0] m_committed;
    int          m_cnt;

    always #5 clk = ~clk;

    keypad_scan #(
        .clk_freq       (1000),
        .row_per_us     (4),
        .debounce_scans (DEB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_press (key_press),
        .key_valid (key_valid),
        .key_ready (key_ready)
    );

    // Keypad: a pressed key shorts its row line onto its column line.
    always_comb begin
        col_n = glitch_n;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_n[r] && keys[r*4+c]) col_n[c] = 1'b0;
    end

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       key_ready = 1'b0;
            1:       key_ready = 1'b1;
            default: key_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    function automatic void check(input bit ok, input string name,
                                  input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Reference: one call per whole frame of key state.
    task automatic model_step(input logic [15:0] f);
        if (f == m_prev) begin
            if (m_cnt < DEB) m_cnt++;
        end else begin
            m_cnt = 0;
        end
        m_prev = f;
        if (m_cnt == DEB && f != m_committed) begin
            for (int k = 0; k < 16; k++)
                if (f[k] != m_committed[k]) exp_q.push_back({4'(k), f[k]});
            m_committed = f;
        end
    endtask

    task automatic model_reset();
        m_prev      = '0;
        m_committed = '0;
        m_cnt       = 0;
        exp_q.delete();
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (rst) begin
            st_hold = 1'b0;
        end else begin
            check($countones(~row_n) <= 1, "row_onehot", row_n, 4'hF);
            if (st_hold)
                check(key_valid && {key_code, key_press} == st_ev, "hold_stable",
                      {key_valid, key_code, key_press}, {1'b1, st_ev});
            if (key_valid)
                check(row_n == 4'hF, "emit_rows_idle", row_n, 4'hF);
            st_hold = key_valid && !key_ready;
            st_ev   = {key_code, key_press};
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_event", {key_code, key_press}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check({key_code, key_press} == mon_e, "event",
                          {key_code, key_press}, mon_e);
                end
            end
        end
    end

    task automatic wait_fs(output bit ok);
        logic [3:0] last;
        last = row_n;
        ok   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (row_n == 4'b1110 && last != 4'b1110) begin
                ok = 1'b1;
                break;
            end
            last = row_n;
        end
        if (!ok) check(1'b0, "frame_start_timeout", row_n, 4'b1110);
    endtask

    task automatic frame(input logic [15:0] f);
        bit ok;
        wait_fs(ok);
        check(exp_q.size() == 0, "events_drained", exp_q.size(), 0);
        keys = f;
        model_step(f);
    endtask

    task automatic wait_valid();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (key_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(seen, "emit_timeout", key_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  er;
        logic [15:0] pat;
        bit          ok;

        rst      = 1'b1;
        keys     = '0;
        glitch_n = 4'hF;
        rdy_mode = 1;
        model_reset();
        repeat (3) @(negedge clk);
        check(row_n == 4'hF, "rst_row_n", row_n, 4'hF);
        check(key_valid == 1'b0, "rst_key_valid", key_valid, 0);
        check(key_code == 4'h0, "rst_key_code", key_code, 0);
        check(key_press == 1'b0, "rst_key_press", key_press, 0);
        rst = 1'b0;
        @(negedge clk);
        check(row_n == 4'b1110, "first_row_after_rst", row_n, 4'b1110);

        // Idle: row sequence over one frame, then more idle frames
        model_step(16'h0000);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            er = ~(4'b0001 << (i / 4));
            check(row_n == er, "row_sequence", row_n, er);
        end
        repeat (9) frame(16'h0000);

        // Key 5 held clean, then released
        repeat (5) frame(16'h0020);
        repeat (5) frame(16'h0000);

        // Key 5 bouncing for two frames, then held
        frame(16'h0020); frame(16'h0000);
        frame(16'h0020); frame(16'h0000);
        repeat (6) frame(16'h0020);
        repeat (5) frame(16'h0000);

        // Two-cycle column glitch between sample points
        frame(16'h0000);
        repeat (6) @(negedge clk);
        glitch_n = 4'b1101;
        repeat (2) @(negedge clk);
        glitch_n = 4'hF;
        repeat (4) frame(16'h0000);

        // Keys 2 and 9 together with consumer stalled
        rdy_mode = 0;
        repeat (4) frame(16'h0204);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            check(key_valid && key_code == 4'd2, "stall_code", key_code, 2);
            check(row_n == 4'hF, "stall_rows", row_n, 4'hF);
            @(negedge clk);
        end
        rdy_mode = 1;
        for (int n = 0; n < 5 && !key_ready; n++) @(negedge clk);
        @(negedge clk);
        check(key_valid && key_code == 4'd9 && key_press, "back_to_back_9",
              {key_valid, key_code}, {1'b1, 4'd9});
        @(negedge clk);
        check(!key_valid && row_n == 4'b1110, "scan_resume_row0",
              {key_valid, row_n}, {1'b0, 4'b1110});
        model_step(16'h0204);
        repeat (2) frame(16'h0204);
        repeat (5) frame(16'h0000);

        // Reset while an event for key 2 is pending
        rdy_mode = 0;
        repeat (4) frame(16'h0004);
        wait_valid();
        check(key_code == 4'd2, "pending_code", key_code, 2);
        rst = 1'b1;
        @(negedge clk);
        check(key_valid == 1'b0, "valid_after_rst", key_valid, 0);
        rst = 1'b0;
        model_reset();
        rdy_mode = 1;
        @(negedge clk);
        check(row_n == 4'b1110, "row0_after_rst", row_n, 4'b1110);
        model_step(16'h0004);
        repeat (5) frame(16'h0004);
        repeat (5) frame(16'h0000);

        // Randomized key patterns with a randomly stalling consumer
        rdy_mode = 2;
        pat = '0;
        repeat (40) begin
            if ($urandom_range(0, 3) == 0)
                pat = 16'($urandom) & 16'($urandom) & 16'($urandom);
            frame(pat);
        end
        repeat (5) frame(16'h0000);

        wait_fs(ok);
        check(exp_q.size() == 0, "final_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
